div_unit: RTL
=============

Name: div_unit

Overview:
- Iterative radix-2 restoring divider implementing RV32M DIV, DIVU, REM and REMU.
- Consumes rs1/rs2 operands straight from the register file read ports.
- Returns the quotient or remainder, with its destination register index, for write-back into the register file.
- Control stalls the core while busy_o is high and writes back on the result handshake.

Parameters:
- DataWidth, 32: operand/result width.
- AddressWidth, 5: destination register index width.

Ports:
- clk_i  input  1  clock, rising-edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  request a divide; sampled only in IDLE.
- op_i  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend_i  input  DataWidth  rs1 value.
- divisor_i  input  DataWidth  rs2 value.
- rd_i  input  AddressWidth  destination register index.
- busy_o  output  1  high whenever state is not IDLE.
- result_valid_o  output  1  result_o/rd_o valid.
- result_ready_i  input  1  consumer accepts the result.
- result_o  output  DataWidth  quotient or remainder.
- rd_o  output  AddressWidth  latched rd_i.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is asynchronous, active-high.
- Reset: state=IDLE, busy_o=0, result_valid_o=0, result_o=0, rd_o=0, iteration counter=0. Assertion mid-operation aborts immediately; no result is produced.
- States and transitions:
  - IDLE: on start_i=1 at a rising edge (the accept edge E0), latch op_i, rd_i and operands, then go to CALC. start_i is ignored in every other state.
  - On accept:
    - Signed ops (DIV/REM) latch the magnitudes of the operands plus the sign of each.
    - Unsigned ops latch the raw operands.
    - Partial remainder = 0; counter = 0.
  - CALC: one quotient bit per edge, MSB first:
    - Shift {rem, dividend} left by 1.
    - Trial-subtract the divisor at DataWidth+1 bits.
    - If no borrow, keep the difference and set the quotient bit.
    - Counter increments each edge.
    - After the iteration with counter=DataWidth-1 (edge E_DataWidth), register the final result and go to DONE.
  - Final result rules:
    - DIV quotient is negated iff operand signs differ.
    - REM remainder takes the sign of the dividend.
    - Divisor = 0: quotient = all ones (DIV and DIVU); remainder = dividend (unmodified, original signed value).
    - Signed overflow (dividend 0x80000000, divisor 0xFFFFFFFF, DIV/REM): quotient 0x80000000, remainder 0.
    - result_o selects the quotient for op_i[1]=0, the remainder for op_i[1]=1.
  - DONE: result_valid_o=1; result_o and rd_o are held stable. When result_ready_i=1 at an edge, go to IDLE and drop result_valid_o. Otherwise hold indefinitely.
- Latency: accept at E0, result_valid_o high in the cycle after E_DataWidth (DataWidth+1 edges after the start cycle). If result_ready_i is tied high, the unit is back in IDLE after E_DataWidth+1.
- Back-to-back: a new start_i is accepted in the cycle after the handshake edge (IDLE). There is no start/handshake overlap.
- Widths: all arithmetic is internally DataWidth+1 bits. Magnitude of 0x80000000 is 0x80000000 unsigned (no overflow).

Optional Feature:
- Macro: DIV_UNIT_EARLY_OUT_EN.
- Defined: divisor = 0 or signed overflow detected at accept skips CALC. The state goes IDLE->DONE at E0, with the special-case result registered at E0, so result_valid_o is high in the cycle after E0.
- Not defined: special cases run the full DataWidth CALC iterations. The final result is forced to the special-case values above, with latency identical to the normal case.

Test Plan:
- DIVU 100 / 7, rd=5, ready tied 1 -> result_valid_o after 32 CALC edges, result_o=14, rd_o=5; REMU same operands -> 2.
- DIV -7 (0xFFFFFFF9) / 2 -> 0xFFFFFFFD (-3); REM -7 / 2 -> 0xFFFFFFFF (-1); REM 7 / -2 -> 1.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0. DIVU 5 / 0 -> 0xFFFFFFFF; REM -5 / 0 -> 0xFFFFFFFB. Check latency 1 with DIV_UNIT_EARLY_OUT_EN defined, 32 without.
- Backpressure: result_ready_i=0 for 10 cycles in DONE -> result_valid_o, result_o, rd_o stable, busy_o=1. start_i pulses during CALC/DONE are ignored. Ready=1 -> IDLE on the next edge.
- Reset mid-CALC (counter=10): rst_i asserted between edges -> busy_o=0, result_valid_o=0 immediately. After release, a new DIVU 9/3 completes normally with result 3.
- Back-to-back: DIVU 1000/10 then REMU 1000/7, start_i asserted in the first IDLE cycle -> results 100 then 6, each with full latency.

Source files
------------

// File: rtl/div_unit_if.sv
// Request/result bundle between the core control and the iterative divider.
// The master drives the request and the result acceptance; the slave is the divider.
interface div_unit_if #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 5
);
  logic                    start_i;
  logic [1:0]              op_i;
  logic [DataWidth-1:0]    dividend_i;
  logic [DataWidth-1:0]    divisor_i;
  logic [AddressWidth-1:0] rd_i;
  logic                    busy_o;
  logic                    result_valid_o;
  logic                    result_ready_i;
  logic [DataWidth-1:0]    result_o;
  logic [AddressWidth-1:0] rd_o;

  // Result handshake: a result transfers on a rising edge where result_valid_o and
  // result_ready_i are both high; result_o/rd_o stay stable while valid waits for ready.
  modport master (
    output start_i, op_i, dividend_i, divisor_i, rd_i, result_ready_i,
    input  busy_o, result_valid_o, result_o, rd_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, rd_i, result_ready_i,
    output busy_o, result_valid_o, result_o, rd_o
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock.
// Optional macro DIV_UNIT_EARLY_OUT_EN: divide-by-zero and signed overflow go straight to DONE.
module div_unit #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  div_unit_if.slave  bus,
  output logic [1:0] dbg_state
);
  localparam int CntWidth = $clog2(DataWidth);
  localparam logic [CntWidth-1:0]  LastCnt = CntWidth'(DataWidth - 1);
  localparam logic [DataWidth-1:0] MinVal  = {1'b1, {(DataWidth-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t               state;
  logic [CntWidth-1:0]  cnt;
  logic [DataWidth-1:0] rem;
  logic [DataWidth-1:0] quo;
  logic [DataWidth-1:0] dvsr;
  logic                 rem_sel;
  logic                 neg_q;
  logic                 neg_r;
  logic                 spec_hit;
  logic [DataWidth-1:0] spec_res;

  // Operand preparation and special-case detection on the request inputs.
  logic                 is_signed;
  logic                 a_neg;
  logic                 b_neg;
  logic [DataWidth-1:0] a_mag;
  logic [DataWidth-1:0] b_mag;
  logic                 div_zero;
  logic                 ovf;
  logic [DataWidth-1:0] spec_res_in;

  always_comb begin
    is_signed   = ~bus.op_i[0];
    a_neg       = is_signed & bus.dividend_i[DataWidth-1];
    b_neg       = is_signed & bus.divisor_i[DataWidth-1];
    a_mag       = a_neg ? -bus.dividend_i : bus.dividend_i;
    b_mag       = b_neg ? -bus.divisor_i : bus.divisor_i;
    div_zero    = (bus.divisor_i == '0);
    ovf         = is_signed && (bus.dividend_i == MinVal) && (&bus.divisor_i);
    spec_res_in = '0;
    if (div_zero) begin
      spec_res_in = bus.op_i[1] ? bus.dividend_i : '1;
    end else if (ovf) begin
      spec_res_in = bus.op_i[1] ? '0 : MinVal;
    end
  end

  // One restoring step; the MSB of the DataWidth+1 bit difference is the borrow.
  logic [DataWidth:0]   shifted;
  logic [DataWidth:0]   diff;
  logic                 borrow;
  logic [DataWidth-1:0] rem_next;
  logic [DataWidth-1:0] quo_next;
  logic [DataWidth-1:0] q_fin;
  logic [DataWidth-1:0] r_fin;
  logic [DataWidth-1:0] final_res;

  always_comb begin
    shifted   = {rem, quo[DataWidth-1]};
    diff      = shifted - {1'b0, dvsr};
    borrow    = diff[DataWidth];
    rem_next  = borrow ? shifted[DataWidth-1:0] : diff[DataWidth-1:0];
    quo_next  = {quo[DataWidth-2:0], ~borrow};
    q_fin     = neg_q ? -quo_next : quo_next;
    r_fin     = neg_r ? -rem_next : rem_next;
    final_res = spec_hit ? spec_res : (rem_sel ? r_fin : q_fin);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state              <= IDLE;
      cnt                <= '0;
      rem                <= '0;
      quo                <= '0;
      dvsr               <= '0;
      rem_sel            <= 1'b0;
      neg_q              <= 1'b0;
      neg_r              <= 1'b0;
      spec_hit           <= 1'b0;
      spec_res           <= '0;
      bus.busy_o         <= 1'b0;
      bus.result_valid_o <= 1'b0;
      bus.result_o       <= '0;
      bus.rd_o           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            cnt        <= '0;
            rem        <= '0;
            quo        <= a_mag;
            dvsr       <= b_mag;
            rem_sel    <= bus.op_i[1];
            neg_q      <= a_neg ^ b_neg;
            neg_r      <= a_neg;
            spec_hit   <= div_zero | ovf;
            spec_res   <= spec_res_in;
            bus.rd_o   <= bus.rd_i;
            bus.busy_o <= 1'b1;
`ifdef DIV_UNIT_EARLY_OUT_EN
            if (div_zero || ovf) begin
              bus.result_o       <= spec_res_in;
              bus.result_valid_o <= 1'b1;
              state              <= DONE;
            end else begin
              state <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end
        CALC: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + 1'b1;
          if (cnt == LastCnt) begin
            bus.result_o       <= final_res;
            bus.result_valid_o <= 1'b1;
            state              <= DONE;
          end
        end
        DONE: begin
          if (bus.result_ready_i) begin
            bus.result_valid_o <= 1'b0;
            bus.busy_o         <= 1'b0;
            state              <= IDLE;
          end
        end
        default: begin
          bus.busy_o         <= 1'b0;
          bus.result_valid_o <= 1'b0;
          state              <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;
endmodule
